// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  localparam int MD_LATENCY_DEFAULT = 4;
  localparam int REG_W  = 5;
  localparam int CNT_W  = 4;
  localparam int STAT_W = 16;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } hazState_t;

  // Saturating increment for the statistics counters.
  function automatic logic [STAT_W-1:0] satInc(input logic [STAT_W-1:0] value);
    return (&value) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// Combinational load-use hazard compare between the ID sources and the EX load destination.
module load_use_detect
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] rs_id,
  input  logic [REG_W-1:0] rt_id,
  input  logic             re1_id,
  input  logic             re2_id,
  input  logic [REG_W-1:0] ws_ex,
  input  logic             we_ex,
  input  logic             mem_read_ex,
  output logic             loadUse
);

  logic [REG_W-1:0] srcReg [2];
  logic [1:0]       srcRe;
  logic [1:0]       srcHit;

  assign srcReg[0] = rs_id;
  assign srcReg[1] = rt_id;
  assign srcRe     = {re2_id, re1_id};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gSrc
      assign srcHit[gi] = srcRe[gi] && (srcReg[gi] == ws_ex);
    end
  endgenerate

  // r0 is hard-wired zero, so a load targeting it can never feed a consumer.
  assign loadUse = mem_read_ex && we_ex && (ws_ex != '0) && (|srcHit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, mul/div occupancy, memory freeze.
// Optional statistics counters are enabled with `define HAZARD_CTRL_STATS_EN.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rs_id,
  input  logic [REG_W-1:0] rt_id,
  input  logic             re1_id,
  input  logic             re2_id,
  input  logic [REG_W-1:0] ws_ex,
  input  logic             we_ex,
  input  logic             mem_read_ex,
  input  logic             branch_taken_ex,
  input  logic             md_start_ex,
  input  logic             mem_wait,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_bubble,
  output logic             md_busy,
  output logic             md_done
`ifdef HAZARD_CTRL_STATS_EN
  ,
  output logic [STAT_W-1:0] stall_cnt,
  output logic [STAT_W-1:0] flush_cnt
`endif
);

  localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_LATENCY - 1);

  hazState_t        stateReg, stateNext;
  logic [CNT_W-1:0] mdCntReg, mdCntNext;
  logic             doneOwedReg, doneOwedNext;
  logic             loadUse;

  load_use_detect uLoadUse (
    .rs_id       (rs_id),
    .rt_id       (rt_id),
    .re1_id      (re1_id),
    .re2_id      (re2_id),
    .ws_ex       (ws_ex),
    .we_ex       (we_ex),
    .mem_read_ex (mem_read_ex),
    .loadUse     (loadUse)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg    <= RUN;
      mdCntReg    <= '0;
      doneOwedReg <= 1'b0;
    end else begin
      stateReg    <= stateNext;
      mdCntReg    <= mdCntNext;
      doneOwedReg <= doneOwedNext;
    end
  end

  always_comb begin
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    idex_we      = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    md_busy      = 1'b0;
    md_done      = 1'b0;
    stateNext    = stateReg;
    mdCntNext    = mdCntReg;
    doneOwedNext = doneOwedReg;

    if (rst) begin
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      idex_we      = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      exmem_bubble = 1'b1;
      stateNext    = RUN;
      mdCntNext    = '0;
      doneOwedNext = 1'b0;
    end else begin
      case (stateReg)
        RUN: begin
          // A completion that expired under mem_wait is reported once memory is ready.
          if (doneOwedReg && !mem_wait) begin
            md_done      = 1'b1;
            doneOwedNext = 1'b0;
          end
          if (mem_wait) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            idex_we = 1'b0;
          end else begin
            if (branch_taken_ex) begin
              ifid_flush  = 1'b1;
              idex_bubble = 1'b1;
            end else if (loadUse) begin
              pc_we       = 1'b0;
              ifid_we     = 1'b0;
              idex_bubble = 1'b1;
            end
            if (md_start_ex && !branch_taken_ex) begin
              stateNext = MD_BUSY;
              mdCntNext = MD_LOAD;
            end
          end
        end
        MD_BUSY: begin
          md_busy      = 1'b1;
          pc_we        = 1'b0;
          ifid_we      = 1'b0;
          idex_we      = 1'b0;
          exmem_bubble = !mem_wait;
          // The count keeps running through a memory freeze.
          mdCntNext    = mdCntReg - 1'b1;
          if (mdCntReg == CNT_W'(1)) begin
            stateNext = RUN;
            if (mem_wait) doneOwedNext = 1'b1;
            else          md_done      = 1'b1;
          end
        end
        default: begin
          stateNext = RUN;
          mdCntNext = '0;
        end
      endcase
    end
  end

`ifdef HAZARD_CTRL_STATS_EN
  logic [STAT_W-1:0] stallCntReg, flushCntReg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stallCntReg <= '0;
      flushCntReg <= '0;
    end else begin
      if (!pc_we)     stallCntReg <= satInc(stallCntReg);
      if (ifid_flush) flushCntReg <= satInc(flushCntReg);
    end
  end

  assign stall_cnt = stallCntReg;
  assign flush_cnt = flushCntReg;
`endif

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MD_LATENCY, default 4, SHALL set the EX-stage occupancy of a mul/div instruction in cycles (legal range 2..15).
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 rs_id, rt_id  in  5 each  source register numbers of the instruction in ID.
REQ-005 re1_id, re2_id  in  1 each  rs/rt read enables of the instruction in ID.
REQ-006 ws_ex  in  5  destination register of the instruction in EX; we_ex  in  1  its write enable.
REQ-007 mem_read_ex  in  1  instruction in EX is a load.
REQ-008 branch_taken_ex  in  1  EX resolved a taken branch or jump this cycle.
REQ-009 md_start_ex  in  1  a mul/div instruction entered EX this cycle.
REQ-010 mem_wait  in  1  data memory not ready; freeze the whole pipeline.
REQ-011 pc_we, ifid_we, idex_we  out  1 each  write enables of the PC, IF/ID and ID/EX registers.
REQ-012 ifid_flush, idex_bubble, exmem_bubble  out  1 each  replace IF/ID, ID/EX or EX/MEM contents with a NOP.
REQ-013 md_busy  out  1  mul/div sequence in progress; md_done  out  1  final mul/div cycle.

Function
REQ-014 The FSM SHALL have exactly two states, RUN and MD_BUSY, plus a 4-bit down-counter md_cnt.
REQ-015 Default outputs in RUN with no event SHALL be: all write enables 1, all flush/bubble outputs 0, md_busy 0, md_done 0.
REQ-016 Load-use SHALL be detected when mem_read_ex && we_ex && ws_ex!=0 && ((re1_id && rs_id==ws_ex) || (re2_id && rt_id==ws_ex)).
REQ-017 On load-use in RUN, the same cycle SHALL give pc_we=0, ifid_we=0 and idex_bubble=1, for exactly one cycle (zero-latency combinational decode).
REQ-018 On branch_taken_ex in RUN, the same cycle SHALL give ifid_flush=1 and idex_bubble=1, with pc_we=1.
REQ-019 Branch SHALL beat load-use: when both occur, the load-use stall is suppressed.
REQ-020 md_start_ex in RUN without branch_taken_ex SHALL move the FSM to MD_BUSY next cycle and load md_cnt=MD_LATENCY-1; md_start_ex together with branch_taken_ex SHALL be ignored.
REQ-021 In MD_BUSY: pc_we=ifid_we=idex_we=0, exmem_bubble=1, md_busy=1; md_cnt decrements each cycle.
REQ-022 In MD_BUSY, when md_cnt==1, md_done SHALL be 1 and the next state SHALL be RUN, giving exactly MD_LATENCY-1 stall cycles after the start cycle.
REQ-023 In MD_BUSY, branch_taken_ex, md_start_ex and load-use SHALL be ignored.
REQ-024 mem_wait=1 SHALL force all write enables to 0 and all flush/bubble outputs to 0, and SHALL take priority over all other events.
REQ-025 During mem_wait, md_cnt SHALL continue to decrement; if the count expires, the RUN transition is taken, but md_done is masked until mem_wait deasserts.
REQ-026 Register 0 SHALL never cause a stall.

Reset
REQ-027 With rst high at a clock edge, the state SHALL become RUN and md_cnt SHALL become 0.
REQ-028 While rst is high, outputs SHALL be: write enables 0; ifid_flush, idex_bubble and exmem_bubble 1; md_busy and md_done 0.
REQ-029 Reset asserted mid-MD_BUSY SHALL abort the sequence with no md_done pulse.

Configuration
REQ-030 With HAZARD_CTRL_STATS_EN defined, the block SHALL add two outputs: stall_cnt (16 bits, counts cycles with pc_we=0 while rst=0) and flush_cnt (16 bits, counts ifid_flush pulses).
REQ-031 Both counters SHALL saturate at 16'hFFFF and clear on rst.
REQ-032 Without HAZARD_CTRL_STATS_EN, those ports and counters SHALL be absent.

Structure
REQ-033 The state encoding (RUN=0, MD_BUSY=1) and the MD_LATENCY default SHALL live in the shared package hazard_pkg.
REQ-034 Load-use comparison SHALL be a sub-module named load_use_detect (purely combinational); all other logic is in hazard_ctrl.

Verification
REQ-035 Load-use: ws_ex=5, we_ex=1, mem_read_ex=1, rs_id=5, re1_id=1 -> exactly one cycle of pc_we=0, ifid_we=0, idex_bubble=1.
REQ-036 Load-use to register 0: ws_ex=0, rs_id=0 -> no stall.
REQ-037 Branch with load-use: branch_taken_ex=1 in the same cycle as a load-use hit -> ifid_flush=1, idex_bubble=1, pc_we=1.
REQ-038 Mul/div: md_start_ex pulse with MD_LATENCY=4 -> md_busy high for 3 cycles and md_done on the 3rd; a branch injected during this window has no effect.
REQ-039 Memory wait during mul/div: mem_wait held 2 cycles mid-MD_BUSY -> all outputs frozen (write enables 0, bubbles 0); return to RUN on schedule; md_done appears after mem_wait drops.
REQ-040 Reset mid-operation: rst mid-MD_BUSY -> next cycle in RUN, md_done never pulses; with HAZARD_CTRL_STATS_EN, stall_cnt and flush_cnt read 0.
